image_window_reader: RTL and testbench
======================================

Name: image_window_reader

Overview:
- Pixel-source stage between the video timing counters and the video_lvds encoder.
- Takes the raster position and sync/DE from the timing generator and addresses the image RAM (IMG_W x IMG_H, one 24-bit pixel per address).
- Upscales the image by 2^SCALE_LOG2 into a window at a programmable screen offset.
- Outputs Red/Green/Blue with HSync/VSync/DataEnable delayed by the same pipeline latency, so the encoder sees aligned data.

Parameters:
- SCREEN_X, 1366, active pixels per line
- SCREEN_Y, 768, active lines per frame
- IMG_W, 100, image width in source pixels
- IMG_H, 100, image height in source pixels
- SCALE_LOG2, 2, upscale factor = 2^SCALE_LOG2 (window is 400x400 by default)
- ADDR_W, 14, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- BG_COLOR, 24'h000000, {R,G,B} shown for active pixels outside the window

Ports:
- clk  in  1  pixel clock (DotClock domain)
- rst_n  in  1  asynchronous active-low reset
- hsync_in  in  1  HSync from timing generator, aligned with pos_x/pos_y
- vsync_in  in  1  VSync from timing generator
- de_in  in  1  DataEnable from timing generator
- pos_x  in  11  current column
- pos_y  in  11  current line
- win_x0  in  11  window left edge, sampled at frame start
- win_y0  in  11  window top edge, sampled at frame start
- enable  in  1  window display enable, sampled at frame start
- ram_addr  out  ADDR_W  image RAM read address
- ram_en  out  1  RAM read enable, high only for in-window pixels
- ram_r, ram_g, ram_b  in  8 each  RAM read data, valid one clk after ram_addr/ram_en
- red, green, blue  out  8 each  pixel to encoder
- hsync_out, vsync_out, de_out  out  1 each  sync/DE delayed to match pixel data
- frame_done  out  1  one-cycle pulse when the last image address is issued

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0, except hsync_out and vsync_out, which go to 1 (inactive).
  - All pipeline valid bits clear.
  - Shadow registers: win_x0/win_y0 = 0, enable = 0.
- Frame start is the cycle with pos_x==0 && pos_y==0. On that cycle the shadow registers load win_x0, win_y0 and enable. These values govern the whole frame; mid-frame input changes take effect at the next frame start.
- Stage 1, registered at t+1 for inputs at t:
  - rel_x = pos_x - x0s, rel_y = pos_y - y0s (11-bit unsigned).
  - in_win = de_in & en_s & pos_x>=x0s & pos_y>=y0s & rel_x < IMG_W<<SCALE_LOG2 & rel_y < IMG_H<<SCALE_LOG2.
  - Comparisons use 12-bit arithmetic, so a window running past SCREEN_X/SCREEN_Y is clipped, never wrapped.
- Stage 2, registered at t+2:
  - ram_addr = (rel_y>>SCALE_LOG2)*IMG_W + (rel_x>>SCALE_LOG2), truncated to ADDR_W; ram_en = in_win.
  - When !in_win, ram_addr holds its previous value.
- Stage 3, registered at t+3: RAM data arrives (fixed 1-cycle RAM latency).
- Stage 4, registered at t+4:
  - in_win: {red,green,blue} = {ram_r,ram_g,ram_b}.
  - de && !in_win: BG_COLOR.
  - !de: 0.
- Total latency from inputs to outputs is exactly 4 clk. hsync/vsync/de pass through a 4-deep shift register; no glitch or skew between them and the RGB outputs.
- frame_done: single-cycle pulse, asserted in the same cycle ram_addr == IMG_W*IMG_H-1 is issued with ram_en=1 on the window's last pixel (bottom-right).
  - The upscaled last source pixel is issued on 2^SCALE_LOG2 consecutive cycles; only the first of these pulses.
  - Tracked with a latch that re-arms at frame start.
  - No pulse in frames with en_s=0 or a fully clipped window.
- Reset asserted mid-frame:
  - Pipeline flushes immediately.
  - After release, outputs show blanking (de_out=0) until valid inputs propagate through the 4 stages.
  - Window stays disabled until the next frame start.

Test Plan:
- Reset release, enable=1, win=(0,0) set before frame start, run to first active pixel -> de_out rises exactly 4 clk after de_in; pixel (0,0) RGB = RAM[0].
- Addressing with window (100,50), SCALE_LOG2=2:
  - pos (100..103, 50) -> ram_addr=0 for 4 cycles; pos 104 -> addr 1.
  - Line 54 -> row 1, pos_x 100 -> addr 100.
  - pos (499, 449) -> addr 9999 with frame_done single pulse.
- Window (1200,700): columns >=1366 and lines >=768 never addressed; ram_en=0 there; no frame_done; active pixels outside window = BG_COLOR.
- win_x0 changed from 0 to 300 mid-frame -> current frame unchanged; next frame the left edge is at 300.
- enable=0 at frame start -> ram_en stays 0 all frame; de_out pixels = BG_COLOR; sync outputs still delayed by 4.
- rst_n pulsed low at pos (200,100) -> outputs immediately 0 with hsync_out=vsync_out=1; after release, ram_en stays 0 until the next pos (0,0).

Source files
------------

// File: rtl/image_window_reader_if.sv
// Raster-in / RAM / pixel-out bundle for image_window_reader.
// master = timing generator + RAM + encoder side; slave = the reader itself.
interface image_window_reader_if #(
  parameter int ADDR_W = 14
);
  logic              hsync_in;
  logic              vsync_in;
  logic              de_in;
  logic [10:0]       pos_x;
  logic [10:0]       pos_y;
  logic [10:0]       win_x0;
  logic [10:0]       win_y0;
  logic              enable;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en;
  logic [7:0]        ram_r;
  logic [7:0]        ram_g;
  logic [7:0]        ram_b;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic              hsync_out;
  logic              vsync_out;
  logic              de_out;
  logic              frame_done;

  modport master (
    output hsync_in, vsync_in, de_in, pos_x, pos_y, win_x0, win_y0, enable,
    output ram_r, ram_g, ram_b,
    input  ram_addr, ram_en,
    input  red, green, blue, hsync_out, vsync_out, de_out, frame_done
  );

  modport slave (
    input  hsync_in, vsync_in, de_in, pos_x, pos_y, win_x0, win_y0, enable,
    input  ram_r, ram_g, ram_b,
    output ram_addr, ram_en,
    output red, green, blue, hsync_out, vsync_out, de_out, frame_done
  );
endinterface

// File: rtl/image_window_reader.sv
// Upscaled image window over the raster: addresses the image RAM and emits
// RGB with sync/DE delayed by the same fixed 4-clk pipeline.
module image_window_reader #(
  parameter int          SCREEN_X   = 1366,
  parameter int          SCREEN_Y   = 768,
  parameter int          IMG_W      = 100,
  parameter int          IMG_H      = 100,
  parameter int          SCALE_LOG2 = 2,
  parameter int          ADDR_W     = 14,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  image_window_reader_if.slave io
);
  localparam int STAGES = 4;
  localparam int WIN_W  = IMG_W << SCALE_LOG2;
  localparam int WIN_H  = IMG_H << SCALE_LOG2;
  localparam int LAST   = IMG_W * IMG_H - 1;

  logic              frame_start;
  logic [10:0]       x0s_q, y0s_q;
  logic              en_s_q;
  logic [10:0]       x0_eff, y0_eff;
  logic              en_eff;
  logic [10:0]       rel_x_d, rel_y_d, rel_x_q, rel_y_q;
  logic              in_win_d, in_win_q;
  logic [31:0]       addr_full;
  logic              hit;
  logic [ADDR_W-1:0] ram_addr_d, ram_addr_q;
  logic              ram_en_q;
  logic              armed_d, armed_q;
  logic              frame_done_d, frame_done_q;
  logic              win3_q;
  logic [STAGES:1]   vld_pipe_q, hs_pipe_q, vs_pipe_q;
  logic [23:0]       rgb_d, rgb_q;

  // The frame-start pixel itself already sees the freshly sampled window.
  assign frame_start = (io.pos_x == 11'd0) && (io.pos_y == 11'd0);
  assign x0_eff      = frame_start ? io.win_x0 : x0s_q;
  assign y0_eff      = frame_start ? io.win_y0 : y0s_q;
  assign en_eff      = frame_start ? io.enable : en_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0s_q  <= '0;
      y0s_q  <= '0;
      en_s_q <= 1'b0;
    end else if (frame_start) begin
      x0s_q  <= io.win_x0;
      y0s_q  <= io.win_y0;
      en_s_q <= io.enable;
    end
  end

  // Stage 1: 12-bit compares so a window past the screen edge clips, never wraps.
  assign rel_x_d  = io.pos_x - x0_eff;
  assign rel_y_d  = io.pos_y - y0_eff;
  assign in_win_d = io.de_in & en_eff
                  & ({1'b0, io.pos_x} >= {1'b0, x0_eff})
                  & ({1'b0, io.pos_y} >= {1'b0, y0_eff})
                  & ({1'b0, rel_x_d} < 12'(WIN_W))
                  & ({1'b0, rel_y_d} < 12'(WIN_H))
                  & ({1'b0, io.pos_x} < 12'(SCREEN_X))
                  & ({1'b0, io.pos_y} < 12'(SCREEN_Y));

  // Stage 2: source address; frame_done fires once per frame via the armed latch.
  assign addr_full    = 32'(rel_y_q >> SCALE_LOG2) * 32'(IMG_W)
                      + 32'(rel_x_q >> SCALE_LOG2);
  assign hit          = in_win_q && (addr_full == 32'(LAST));
  assign ram_addr_d   = in_win_q ? addr_full[ADDR_W-1:0] : ram_addr_q;
  assign frame_done_d = hit & armed_q;
  assign armed_d      = frame_start ? 1'b1 : (hit ? 1'b0 : armed_q);

  // Stage 4: RAM data (valid one clk after the address) or background/blank.
  assign rgb_d = win3_q           ? {io.ram_r, io.ram_g, io.ram_b} :
                 vld_pipe_q[3]    ? BG_COLOR : 24'h000000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_x_q      <= '0;
      rel_y_q      <= '0;
      in_win_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_en_q     <= 1'b0;
      armed_q      <= 1'b0;
      frame_done_q <= 1'b0;
      win3_q       <= 1'b0;
      vld_pipe_q   <= '0;
      hs_pipe_q    <= '1;
      vs_pipe_q    <= '1;
      rgb_q        <= '0;
    end else begin
      rel_x_q      <= rel_x_d;
      rel_y_q      <= rel_y_d;
      in_win_q     <= in_win_d;
      ram_addr_q   <= ram_addr_d;
      ram_en_q     <= in_win_q;
      armed_q      <= armed_d;
      frame_done_q <= frame_done_d;
      win3_q       <= ram_en_q;
      vld_pipe_q   <= {vld_pipe_q[STAGES-1:1], io.de_in};
      hs_pipe_q    <= {hs_pipe_q[STAGES-1:1], io.hsync_in};
      vs_pipe_q    <= {vs_pipe_q[STAGES-1:1], io.vsync_in};
      rgb_q        <= rgb_d;
    end
  end

  assign io.ram_addr   = ram_addr_q;
  assign io.ram_en     = ram_en_q;
  assign io.frame_done = frame_done_q;
  assign io.red        = rgb_q[23:16];
  assign io.green      = rgb_q[15:8];
  assign io.blue       = rgb_q[7:0];
  assign io.de_out     = vld_pipe_q[STAGES];
  assign io.hsync_out  = hs_pipe_q[STAGES];
  assign io.vsync_out  = vs_pipe_q[STAGES];
endmodule

// File: tb/tb_image_window_reader.sv
// Directed raster bench for image_window_reader with a RAM model and
// queue scoreboard for pixel (4 clk) and address (2 clk) outputs.
module tb_image_window_reader;
  localparam int          IMG_W = 100;
  localparam int          IMG_H = 100;
  localparam int          SC    = 4;
  localparam logic [23:0] BG    = 24'h123456;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
  } pix_exp_t;

  typedef struct {
    logic [13:0] addr;
    logic        en;
    logic        fd;
  } ram_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  image_window_reader_if #(.ADDR_W(14)) bus ();

  image_window_reader #(
    .SCREEN_X(1366), .SCREEN_Y(768), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .SCALE_LOG2(2), .ADDR_W(14), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io(bus)
  );

  function automatic logic [23:0] pix(input logic [13:0] a);
    return {a[7:0], 2'b00, a[13:8], a[7:0] ^ 8'hA5};
  endfunction

  // Synchronous image RAM, one clk read latency.
  always @(posedge clk) if (bus.ram_en) {bus.ram_r, bus.ram_g, bus.ram_b} <= pix(bus.ram_addr);

  pix_exp_t pq[$];
  ram_exp_t rq[$];
  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;
  int m_x0, m_y0, m_last;
  logic m_en, m_armed;

  task automatic sample();
    pix_exp_t e;
    ram_exp_t r;
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (pq.size() == 4) begin
      e = pq.pop_front();
      n_tests++;
      assert ({bus.red, bus.green, bus.blue} === e.rgb) else begin
        n_fail++; $error("FAIL rgb got %h exp %h", {bus.red, bus.green, bus.blue}, e.rgb);
      end
      n_tests++;
      assert ({bus.hsync_out, bus.vsync_out, bus.de_out} === {e.hs, e.vs, e.de}) else begin
        n_fail++; $error("FAIL sync got %b exp %b", {bus.hsync_out, bus.vsync_out, bus.de_out}, {e.hs, e.vs, e.de});
      end
    end
    if (rq.size() == 2) begin
      r = rq.pop_front();
      n_tests++;
      assert ({bus.ram_en, bus.frame_done} === {r.en, r.fd}) else begin
        n_fail++; $error("FAIL en_fd got %b exp %b", {bus.ram_en, bus.frame_done}, {r.en, r.fd});
      end
      n_tests++;
      assert (bus.ram_addr === r.addr) else begin
        n_fail++; $error("FAIL ram_addr got %0d exp %0d", bus.ram_addr, r.addr);
      end
    end
  endtask

  task automatic drive(input int x, input int y, input logic de, input logic hs, input logic vs);
    pix_exp_t e;
    ram_exp_t r;
    logic inw;
    int a;
    bus.pos_x = 11'(x); bus.pos_y = 11'(y);
    bus.de_in = de; bus.hsync_in = hs; bus.vsync_in = vs;
    if (x == 0 && y == 0) begin
      m_x0 = int'(bus.win_x0); m_y0 = int'(bus.win_y0); m_en = bus.enable; m_armed = 1'b1;
    end
    inw = de && m_en && x >= m_x0 && y >= m_y0 && (x - m_x0) < IMG_W * SC && (y - m_y0) < IMG_H * SC;
    a = ((y - m_y0) / SC) * IMG_W + (x - m_x0) / SC;
    r.fd = 1'b0;
    if (inw) begin
      m_last = a;
      r.fd = m_armed && (a == IMG_W * IMG_H - 1);
      if (r.fd) m_armed = 1'b0;
    end
    r.addr = 14'(m_last); r.en = inw;
    e.hs = hs; e.vs = vs; e.de = de;
    e.rgb = inw ? pix(14'(a)) : (de ? BG : 24'h0);
    pq.push_back(e);
    rq.push_back(r);
  endtask

  task automatic step(input int x, input int y, input logic de);
    @(posedge clk); #1;
    sample();
    drive(x, y, de, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic line(input int y, input int xa, input int xb, input logic de);
    for (int x = xa; x <= xb; x++) step(x, y, de);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1500, 900, 1'b0);
  endtask

  task automatic do_reset();
    pix_exp_t e;
    ram_exp_t r;
    rst_n = 1'b0;
    #1;
    n_tests++;
    assert ({bus.red, bus.green, bus.blue, bus.hsync_out, bus.vsync_out, bus.de_out} === {24'h0, 3'b110})
      else begin n_fail++; $error("FAIL reset_pix got %h/%b%b%b", {bus.red, bus.green, bus.blue},
                                  bus.hsync_out, bus.vsync_out, bus.de_out); end
    n_tests++;
    assert ({bus.ram_en, bus.frame_done, bus.ram_addr} === 16'h0)
      else begin n_fail++; $error("FAIL reset_ram got en=%b fd=%b addr=%0d", bus.ram_en, bus.frame_done, bus.ram_addr); end
    pq.delete(); rq.delete();
    m_x0 = 0; m_y0 = 0; m_en = 1'b0; m_armed = 1'b0; m_last = 0;
    repeat (2) @(posedge clk);
    #1;
    e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.rgb = 24'h0;
    r.addr = 14'h0; r.en = 1'b0; r.fd = 1'b0;
    repeat (3) pq.push_back(e);
    rq.push_back(r);
    drive(1500, 900, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.win_x0 = 11'd0; bus.win_y0 = 11'd0; bus.enable = 1'b1;
    bus.pos_x = 11'd1500; bus.pos_y = 11'd900;
    bus.de_in = 1'b0; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
    #3;
    do_reset();

    // Window at origin: pixel (0,0) is RAM[0]
    idle(3);
    line(0, 0, 7, 1'b1);
    idle(6);

    // Window (100,50): addressing, row step, last pixel and single frame_done
    bus.win_x0 = 11'd100; bus.win_y0 = 11'd50;
    fd_cnt = 0;
    step(0, 0, 1'b1);
    line(50, 98, 106, 1'b1);
    line(54, 98, 102, 1'b1);
    line(449, 495, 503, 1'b1);
    line(449, 497, 501, 1'b1);
    line(450, 498, 500, 1'b1);
    idle(6);
    n_tests++;
    assert (fd_cnt == 1) else begin n_fail++; $error("FAIL fd_count got %0d exp 1", fd_cnt); end

    // Window (1200,700) clipped by the screen edge
    bus.win_x0 = 11'd1200; bus.win_y0 = 11'd700;
    fd_cnt = 0;
    step(0, 0, 1'b1);
    line(699, 1198, 1202, 1'b1);
    line(700, 1195, 1207, 1'b1);
    line(767, 1360, 1365, 1'b1);
    line(767, 1366, 1370, 1'b0);
    line(768, 1200, 1203, 1'b0);
    idle(6);
    n_tests++;
    assert (fd_cnt == 0) else begin n_fail++; $error("FAIL fd_clip got %0d exp 0", fd_cnt); end

    // Mid-frame window change applies only from the next frame start
    bus.win_x0 = 11'd0; bus.win_y0 = 11'd0;
    step(0, 0, 1'b1);
    line(10, 0, 3, 1'b1);
    bus.win_x0 = 11'd300;
    line(11, 0, 3, 1'b1);
    line(11, 298, 302, 1'b1);
    step(0, 0, 1'b1);
    line(5, 0, 2, 1'b1);
    line(5, 298, 305, 1'b1);
    idle(6);

    // Disabled frame: background only, no RAM reads
    bus.enable = 1'b0;
    step(0, 0, 1'b1);
    line(20, 298, 310, 1'b1);
    line(21, 0, 4, 1'b0);
    idle(6);

    // Reset mid-frame at (200,100), window disabled until next frame start
    bus.enable = 1'b1; bus.win_x0 = 11'd100; bus.win_y0 = 11'd50;
    step(0, 0, 1'b1);
    line(100, 190, 200, 1'b1);
    do_reset();
    line(100, 201, 215, 1'b1);
    idle(4);
    step(0, 0, 1'b1);
    line(50, 99, 105, 1'b1);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
